// File: rtl/wave_ram_ctrl.sv
// rtl/wave_ram_ctrl.sv - Channel 3 wave RAM with CPU port and playback fetch latch
//
// 16 x 8 wave sample RAM shared between the CPU bus (window 0xFF30-0xFF3F)
// and the channel 3 playback fetch path.
//
// Optional feature macro: WAVE_RAM_CPU_ALIAS_EN
//   When defined and ch3_active is high, CPU reads return the playback byte
//   latch and CPU writes land in array[wave_a] instead of array[a[3:0]].
//
// Ports:
//   cery_2mhz    in   1  sole clock, rising edge
//   napu_reset   in   1  asynchronous active-low reset
//   d            inout 8 CPU data bus, driven only during a wave RAM read
//   a            in  16  CPU address
//   ncpu_rd      in   1  CPU read strobe, active-low
//   ncpu_wr      in   1  CPU write strobe, active-low
//   ch3_active   in   1  channel 3 playing
//   atok         in   1  playback fetch strobe, active-low
//   wave_a       in   4  playback byte address
//   efar_q       in   1  nibble select (0 = high nibble, 1 = low nibble)
//   wave_play_d  out  4  current sample nibble
//   wave_ram_rd  out  1  CPU read of the wave window in progress

module wave_ram_ctrl (
  input  logic        cery_2mhz,
  input  logic        napu_reset,
  inout  tri   [7:0]  d,
  input  logic [15:0] a,
  input  logic        ncpu_rd,
  input  logic        ncpu_wr,
  input  logic        ch3_active,
  input  logic        atok,
  input  logic [3:0]  wave_a,
  input  logic        efar_q,
  output logic [3:0]  wave_play_d,
  output logic        wave_ram_rd
);

  logic [7:0] mem_q [16];
  logic [7:0] mem_d [16];
  logic [7:0] latch_q, latch_d;
  logic       wr_edge_q, wr_edge_d;
  // Cleared by reset; set once ncpu_wr has been seen high. A write strobe
  // that was already low when reset released is therefore ignored.
  logic       wr_armed_q, wr_armed_d;

  logic       hit;
  logic       wr_fire;
  logic       drive_en;
  logic       alias_on;
  logic [3:0] cpu_idx;
  logic [7:0] rd_data;

`ifdef WAVE_RAM_CPU_ALIAS_EN
  assign alias_on = ch3_active;
`else
  logic unused_ch3_active;
  assign unused_ch3_active = ch3_active;
  assign alias_on = 1'b0;
`endif

  always_comb begin
    hit         = (a[15:4] == 12'hFF3);
    wave_ram_rd = hit & ~ncpu_rd;
    cpu_idx     = alias_on ? wave_a : a[3:0];
    // One write per bus cycle: only the first edge after ncpu_wr falls.
    wr_fire     = hit & ~ncpu_wr & wr_edge_q & wr_armed_q & napu_reset;
    // Write wins over a simultaneous read: the bus stays released.
    drive_en    = wave_ram_rd & ncpu_wr & napu_reset;
    rd_data     = alias_on ? latch_q : mem_q[a[3:0]];
    wave_play_d = efar_q ? latch_q[3:0] : latch_q[7:4];
  end

  assign d = drive_en ? rd_data : 8'bz;

  always_comb begin
    wr_edge_d  = ncpu_wr;
    wr_armed_d = wr_armed_q | ncpu_wr;
    for (int i = 0; i < 16; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_fire) begin
      mem_d[cpu_idx] = d;
    end
    latch_d = latch_q;
    if (!atok) begin
      // Forward same-edge write data so the fetch never sees stale contents.
      if (wr_fire && (cpu_idx == wave_a)) begin
        latch_d = d;
      end else begin
        latch_d = mem_q[wave_a];
      end
    end
  end

  always_ff @(posedge cery_2mhz or negedge napu_reset) begin
    if (!napu_reset) begin
      latch_q    <= 8'h00;
      wr_edge_q  <= 1'b1;
      wr_armed_q <= 1'b0;
    end else begin
      latch_q    <= latch_d;
      wr_edge_q  <= wr_edge_d;
      wr_armed_q <= wr_armed_d;
    end
  end

  // Sample storage is deliberately not reset so contents survive a reset.
  always_ff @(posedge cery_2mhz) begin
    for (int i = 0; i < 16; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_wave_ram_ctrl.sv
// tb/tb_wave_ram_ctrl.sv - Self-checking bench for wave_ram_ctrl

module tb_wave_ram_ctrl;

  logic        clk;
  logic        napu_reset;
  tri   [7:0]  d_bus;
  logic [7:0]  d_drv;
  logic        d_oe;
  logic [15:0] a;
  logic        ncpu_rd;
  logic        ncpu_wr;
  logic        ch3_active;
  logic        atok;
  logic [3:0]  wave_a;
  logic        efar_q;
  logic [3:0]  wave_play_d;
  logic        wave_ram_rd;

  int checks;
  int errors;

  assign d_bus = d_oe ? d_drv : 8'bz;

  wave_ram_ctrl dut (
    .cery_2mhz   (clk),
    .napu_reset  (napu_reset),
    .d           (d_bus),
    .a           (a),
    .ncpu_rd     (ncpu_rd),
    .ncpu_wr     (ncpu_wr),
    .ch3_active  (ch3_active),
    .atok        (atok),
    .wave_a      (wave_a),
    .efar_q      (efar_q),
    .wave_play_d (wave_play_d),
    .wave_ram_rd (wave_ram_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        exp_rd;
  } vec_t;

  vec_t vecs[34];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
    end
  endtask

  task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
    @(negedge clk);
    a = addr; d_drv = data; d_oe = 1'b1; ncpu_wr = 1'b0;
    @(negedge clk);
    ncpu_wr = 1'b1; d_oe = 1'b0;
  endtask

  task automatic cpu_read(input string name, input logic [15:0] addr,
                          input logic [7:0] exp, input logic exp_rd);
    @(negedge clk);
    a = addr; d_oe = 1'b0; ncpu_rd = 1'b0;
    #1;
    chk({name, "_rd"}, {7'd0, wave_ram_rd}, {7'd0, exp_rd});
    if (exp_rd) chk({name, "_d"}, d_bus, exp);
    @(negedge clk);
    ncpu_rd = 1'b1;
    #1;
    chk({name, "_rd_off"}, {7'd0, wave_ram_rd}, 8'h00);
  endtask

  task automatic fetch(input logic [3:0] wa);
    @(negedge clk);
    wave_a = wa; atok = 1'b0;
    @(negedge clk);
    atok = 1'b1;
  endtask

  task automatic chk_play(input string name, input logic [7:0] exp_byte);
    efar_q = 1'b0;
    #1;
    chk({name, "_hi"}, {4'd0, wave_play_d}, {4'd0, exp_byte[7:4]});
    efar_q = 1'b1;
    #1;
    chk({name, "_lo"}, {4'd0, wave_play_d}, {4'd0, exp_byte[3:0]});
  endtask

  initial begin
    checks = 0; errors = 0;
    napu_reset = 1'b0; d_drv = 8'h00; d_oe = 1'b0; a = 16'h0000;
    ncpu_rd = 1'b1; ncpu_wr = 1'b1; ch3_active = 1'b0; atok = 1'b1;
    wave_a = 4'h0; efar_q = 1'b0;

    for (int i = 0; i < 16; i++) begin
      vecs[i]      = '{1'b1, 16'hFF30 + 16'(i), 8'(8'h11 * i), 1'b0};
      vecs[16 + i] = '{1'b0, 16'hFF30 + 16'(i), 8'(8'h11 * i), 1'b1};
    end
    vecs[32] = '{1'b0, 16'hFF40, 8'h00, 1'b0};
    vecs[33] = '{1'b0, 16'hFF2F, 8'h00, 1'b0};

    #2;
    chk_play("reset_play", 8'h00);
    chk("reset_rd", {7'd0, wave_ram_rd}, 8'h00);
    repeat (2) @(negedge clk);
    napu_reset = 1'b1;
    @(negedge clk);

    // Pattern write / read-back and out-of-window reads
    for (int i = 0; i < 34; i++) begin
      if (vecs[i].wr) cpu_write(vecs[i].addr, vecs[i].data);
      else cpu_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].exp_rd);
    end

    // Fetch with 1-cycle latency and nibble select
    cpu_write(16'hFF35, 8'hA7);
    fetch(4'h5);
    chk_play("fetch5", 8'hA7);

    // Latch holds while atok high, even across ch3_active falling
    ch3_active = 1'b1;
    @(negedge clk); wave_a = 4'hC; ch3_active = 1'b0;
    repeat (3) @(negedge clk);
    chk_play("hold", 8'hA7);

    // Wrap of playback address
    fetch(4'hF);
    chk_play("fetch_f", 8'hFF);
    fetch(4'h0);
    chk_play("fetch_0", 8'h00);

    // Held write strobe: only first edge writes
    @(negedge clk);
    a = 16'hFF33; d_oe = 1'b1; d_drv = 8'h11; ncpu_wr = 1'b0;
    @(negedge clk); d_drv = 8'h22;
    @(negedge clk); d_drv = 8'h33;
    @(negedge clk); d_drv = 8'h44;
    @(negedge clk); ncpu_wr = 1'b1; d_oe = 1'b0;
    cpu_read("held_wr", 16'hFF33, 8'h11, 1'b1);

    // Same-edge fetch and write forwarding
    @(negedge clk);
    a = 16'hFF32; d_oe = 1'b1; d_drv = 8'h5C; ncpu_wr = 1'b0;
    wave_a = 4'h2; atok = 1'b0;
    @(negedge clk);
    ncpu_wr = 1'b1; d_oe = 1'b0; atok = 1'b1;
    chk_play("fwd", 8'h5C);
    cpu_read("fwd_mem", 16'hFF32, 8'h5C, 1'b1);

    // Simultaneous read and write: write wins
    @(negedge clk);
    a = 16'hFF37; d_oe = 1'b1; d_drv = 8'hC3; ncpu_wr = 1'b0; ncpu_rd = 1'b0;
    #1;
    chk("rw_bus", d_bus, 8'hC3);
    @(negedge clk);
    ncpu_wr = 1'b1; ncpu_rd = 1'b1; d_oe = 1'b0;
    cpu_read("rw_mem", 16'hFF37, 8'hC3, 1'b1);

    // Reset clears the latch but not the array
    fetch(4'h5);
    chk_play("pre_rst", 8'hA7);
    @(negedge clk);
    napu_reset = 1'b0;
    #1;
    chk_play("in_rst", 8'h00);
    @(negedge clk);
    napu_reset = 1'b1;
    @(negedge clk);
    chk_play("post_rst", 8'h00);
    cpu_read("rst_keep", 16'hFF35, 8'hA7, 1'b1);

    // Reset mid-write aborts it; the held strobe does not write afterwards
    @(negedge clk);
    a = 16'hFF36; d_oe = 1'b1; d_drv = 8'h99; ncpu_wr = 1'b0;
    #1 napu_reset = 1'b0;
    @(negedge clk);
    napu_reset = 1'b1;
    repeat (2) @(negedge clk);
    ncpu_wr = 1'b1; d_oe = 1'b0;
    cpu_read("rst_abort", 16'hFF36, 8'h66, 1'b1);

`ifdef WAVE_RAM_CPU_ALIAS_EN
    cpu_write(16'hFF39, 8'h3E);
    fetch(4'h9);
    ch3_active = 1'b1;
    cpu_read("alias_rd", 16'hFF30, 8'h3E, 1'b1);
    cpu_write(16'hFF30, 8'h77);
    ch3_active = 1'b0;
    cpu_read("alias_wr9", 16'hFF39, 8'h77, 1'b1);
    cpu_read("alias_wr0", 16'hFF30, 8'h00, 1'b1);
`else
    // Without aliasing, ch3_active has no effect on CPU addressing
    ch3_active = 1'b1;
    wave_a = 4'h9;
    cpu_write(16'hFF30, 8'h77);
    cpu_read("noalias0", 16'hFF30, 8'h77, 1'b1);
    cpu_read("noalias9", 16'hFF39, 8'h99, 1'b1);
    ch3_active = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
